// File: rtl/pc_gen_arb.sv
`default_nettype none
// ============================================================================
// pc_gen_arb : IFU fetch PC generator with fixed-priority redirect arbitration
// Revision   : 1.0
// ============================================================================
module pc_gen_arb #(
  parameter int              XLEN        = 32,
  parameter int              FETCH_BYTES = 16,
  parameter int              N_SRC       = 4,
  parameter logic [XLEN-1:0] BOOT_PC     = 'h8000_0000
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [N_SRC-1:0]                        i_redirect_valid,
  input  logic [N_SRC*XLEN-1:0]                   i_redirect_pc,
  input  logic                                    i_halt,
  input  logic                                    i_fetch_ready,
  output logic                                    o_fetch_valid,
  output logic [XLEN-1:0]                         o_fetch_pc,
  output logic [FETCH_BYTES/4-1:0]                o_fetch_slot_mask,
  output logic [XLEN-1:0]                         o_npc,
  output logic                                    o_redirect_taken,
  output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] o_redirect_src
);

  localparam int              SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int              N_SLOT     = FETCH_BYTES / 4;
  localparam int              OFF_W      = $clog2(FETCH_BYTES) - 2;
  localparam logic [XLEN-1:0] BLOCK_MASK = ~XLEN'(FETCH_BYTES - 1);
  localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   seq_pc;
  logic [XLEN-1:0]   redir_pc;
  logic [SRC_W-1:0]  redir_src;
  logic              redir_any;

  // Ascending scan: the last hit is the highest-priority source.
  always_comb begin
    redir_src = '0;
    redir_pc  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (i_redirect_valid[k]) begin
        redir_src = SRC_W'(k);
        redir_pc  = i_redirect_pc[k*XLEN +: XLEN] & WORD_MASK;
      end
    end
  end

  assign redir_any = (|i_redirect_valid) && !i_rst;
  assign seq_pc    = (pc_q & BLOCK_MASK) + XLEN'(FETCH_BYTES);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (i_rst) begin
      pc_d    = BOOT_PC;
      state_d = ST_BOOT;
    end else if (redir_any) begin
      pc_d    = redir_pc;
      state_d = ST_RUN;
    end else if (i_halt) begin
      state_d = ST_HALT;
      if (state_q == ST_RUN && i_fetch_ready) begin
        pc_d = seq_pc;
      end
    end else if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && i_fetch_ready) begin
      pc_d = seq_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q    <= BOOT_PC;
      state_q <= ST_BOOT;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign o_fetch_valid    = (state_q == ST_RUN);
  assign o_fetch_pc       = pc_q;
  assign o_npc            = pc_d;
  assign o_redirect_taken = redir_any;
  assign o_redirect_src   = redir_any ? redir_src : '0;

  generate
    if (OFF_W == 0) begin : g_single_slot
      assign o_fetch_slot_mask = 1'b1;
    end else begin : g_multi_slot
      logic [OFF_W-1:0] slot_off;
      assign slot_off = pc_q[OFF_W+1:2];
      // Slots before the entry offset belong to bytes skipped by the redirect.
      always_comb begin
        o_fetch_slot_mask = '0;
        for (int i = 0; i < N_SLOT; i++) begin
          o_fetch_slot_mask[i] = (OFF_W'(i) >= slot_off);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/pc_gen_arb.md
Name: pc_gen_arb

Overview:
Parametrised next-generation fetch PC generator for the IFU. It keeps the current fetch-block PC and arbitrates N_SRC redirect sources by fixed priority. It presents a fetch request to the I-cache/fetch stage with a valid/ready handshake and supports a halt mode for WFI/fence.i drain. It also produces a per-slot valid mask for the fetch block, where each slot is one 4-byte instruction.

Parameters:
XLEN, 32, PC width in bits.
FETCH_BYTES, 16, fetch block size in bytes; power of 2, 4..64.
N_SRC, 4, number of redirect sources; 1..8; higher index = higher priority (e.g. 3=EXU, 2=IF2, 1=IF1, 0=IF0).
BOOT_PC, 32'h8000_0000, PC loaded by reset.

Ports:
i_clk  in  1  clock, all state on rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_redirect_valid  in  N_SRC  per-source redirect request.
i_redirect_pc  in  N_SRC*XLEN  packed targets; source k at [k*XLEN +: XLEN].
i_halt  in  1  request to stop fetching until next redirect.
i_fetch_ready  in  1  fetch stage accepts o_fetch_pc this cycle.
o_fetch_valid  out  1  fetch request valid.
o_fetch_pc  out  XLEN  current fetch PC (registered).
o_fetch_slot_mask  out  FETCH_BYTES/4  valid 4-byte slots of the current block.
o_npc  out  XLEN  next-cycle PC (combinational, equals next o_fetch_pc).
o_redirect_taken  out  1  a redirect was accepted this cycle (combinational).
o_redirect_src  out  max(1,clog2(N_SRC))  index of the winning source; 0 when none.

Behaviour:
- State regs: pc_q (XLEN), state in {BOOT, RUN, HALT}.
- Reset (i_rst=1 at edge): pc_q<=BOOT_PC, state<=BOOT. o_fetch_pc=BOOT_PC and o_fetch_valid=0 on the cycle after reset is seen; o_npc=BOOT_PC while i_rst=1. All inputs are ignored while i_rst=1. Reset mid-run discards any pending handshake or halt.
- o_fetch_valid = (state==RUN). Combinational in state only; it never depends on i_fetch_ready.
- Winner = highest index k with i_redirect_valid[k]=1. redir_pc = i_redirect_pc[k] with bits[1:0] forced to 0.
- seq_pc = (pc_q & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^XLEN (wraps to 0).
- Next-state priority: reset > redirect > halt > advance > hold.
  - Redirect (any valid, any state): pc_d=redir_pc, state<=RUN. Any handshake in the same cycle is cancelled and the block is not considered fetched.
  - Else i_halt=1: state<=HALT. If RUN and i_fetch_ready=1, the current block is accepted and pc_d=seq_pc; otherwise pc_d=pc_q.
  - Else BOOT: state<=RUN, pc_d=pc_q.
  - Else RUN and i_fetch_ready=1: pc_d=seq_pc.
  - Else: pc_d=pc_q (stall). HALT stays HALT until a redirect arrives.
- o_npc = pc_d. o_redirect_taken = |i_redirect_valid and !i_rst. It is asserted in any state, including BOOT and HALT.
- Slot mask: off = pc_q[log2(FETCH_BYTES)-1:2]. Bit i = (i >= off). FETCH_BYTES=4 gives a constant 1'b1.
- A redirect target equal to pc_q is still treated as a redirect, and the block is refetched.

Test Plan:
1. Boot: default params; i_rst=1 for 2 cycles, then 0, ready=1 -> cycle+1: valid=0, pc=0x8000_0000; then valid=1 with pc 0x8000_0000, 0x8000_0010, 0x8000_0020; mask=4'b1111.
2. Unaligned redirect: src1=0x8000_0109 -> taken=1, src=1, o_npc=0x8000_0108; next pc=0x8000_0108, mask=4'b1100; after accept pc=0x8000_0110, mask=4'b1111.
3. Priority plus stall: ready=0, src0=0x100 and src3=0x200 same cycle -> src=3, pc=0x200. Hold ready=0 for 3 cycles -> pc stays 0x200 and valid stays 1.
4. Halt: in RUN at 0x40 with i_halt=1 and ready=1 -> pc=0x50, state HALT, valid=0. Ready toggling has no effect. src2=0x300 -> next pc=0x300, valid=1.
5. Wrap: redirect to 0xFFFF_FFF4 -> mask=4'b1110. Accept -> pc=0x0000_0000, mask=4'b1111.
6. Mid-run reset: at pc=0x8000_0040 pulse i_rst with redirect valid -> redirect ignored, taken=0; pc=0x8000_0000, valid=0 for one cycle, then 1.
